// File: rtl/sram_play_reader.sv
// sram_play_reader: fetches recorded 16-bit samples back out of external SRAM
// and hands them one per request to the DAC/I2S transmitter.
// Fast playback skips ahead by a stride. Slow playback repeats each stored
// sample several times.
// Optional build macro SRAM_PLAY_INTERP_EN: slow playback produces a linear
// ramp from the previous base sample to the current one instead of holding
// the current sample.
module sram_play_reader #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [2:0]        i_state,
  input  logic              i_fast,
  input  logic [3:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_sample_req,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [4:0]        o_sram_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_play_finished
);

  // Encodings of the recorder's top-level FSM state.
  localparam logic [2:0] TOP_IDLE = 3'd0;
  localparam logic [2:0] TOP_PLAY = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CAPT  = 2'd2
  } fsm_t;

  fsm_t              state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] cur_reg, cur_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              finished_reg, finished_next;

  logic [3:0]        speed_eff;
  logic [3:0]        cnt_plus;
  logic [3:0]        step;
  logic [ADDR_W:0]   addr_plus;
  logic [DATA_W-1:0] cap_sample;
  logic              last_repeat;

`ifdef SRAM_PLAY_INTERP_EN
  logic [DATA_W-1:0]        prev_reg, prev_next;
  logic signed [DATA_W:0]   interp_diff;
  logic signed [DATA_W+5:0] interp_prod;
  logic signed [DATA_W+5:0] interp_quot;
  logic [DATA_W-1:0]        interp_val;
  logic                     unused_quot_bits;
`endif

  // Speed factor: 0 behaves as 1, anything above 8 saturates at 8.
  always_comb begin
    speed_eff = i_speed;
    if (i_speed == 4'd0) begin
      speed_eff = 4'd1;
    end else if (i_speed > 4'd8) begin
      speed_eff = 4'd8;
    end
  end

  // Capture-cycle helpers: which sample is presented, where the next base sample lives.
  always_comb begin
    cnt_plus    = {1'b0, cnt_reg} + 4'd1;
    last_repeat = (cnt_plus >= speed_eff);
    step        = i_fast ? speed_eff : 4'd1;
    // Widened by one bit so stepping past the top of the address space is seen, not wrapped.
    addr_plus   = {1'b0, addr_reg} + {{(ADDR_W-3){1'b0}}, step};
    // Fresh SRAM word on a new base sample; otherwise replay the held one.
    cap_sample  = (i_fast || (cnt_reg == 3'd0)) ? i_sram_data : cur_reg;
  end

`ifdef SRAM_PLAY_INTERP_EN
  // Linear ramp prev + (cur-prev)*(cnt+1)/speed, signed, division truncating toward zero.
  always_comb begin
    interp_diff      = $signed({cap_sample[DATA_W-1], cap_sample}) -
                       $signed({prev_reg[DATA_W-1], prev_reg});
    interp_prod      = $signed({{5{interp_diff[DATA_W]}}, interp_diff}) *
                       $signed({{(DATA_W+2){1'b0}}, cnt_plus});
    interp_quot      = interp_prod / $signed({{(DATA_W+2){1'b0}}, speed_eff});
    // The quotient always lies between 0 and diff, so its low bits are enough.
    interp_val       = prev_reg + interp_quot[DATA_W-1:0];
    unused_quot_bits = ^interp_quot[DATA_W+5:DATA_W];
  end
`endif

  // Next-state and datapath update for the fetch/capture sequence.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    cur_next      = cur_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    finished_next = finished_reg;
`ifdef SRAM_PLAY_INTERP_EN
    prev_next     = prev_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        // Requests are honoured only while playing and not yet at the end.
        if (i_sample_req && (i_state == TOP_PLAY) && !finished_reg) begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        // Address is already on the pins; give the SRAM one cycle to respond.
        state_next = S_CAPT;
      end

      S_CAPT: begin
        state_next = S_IDLE;
        valid_next = 1'b1;
        cur_next   = cap_sample;
        data_next  = cap_sample;
        if (i_fast) begin
          // Stride mode: every request is a new base sample.
          cnt_next = 3'd0;
`ifdef SRAM_PLAY_INTERP_EN
          prev_next = cap_sample;
`endif
        end else begin
`ifdef SRAM_PLAY_INTERP_EN
          data_next = interp_val;
`endif
          if (last_repeat) begin
            cnt_next = 3'd0;
`ifdef SRAM_PLAY_INTERP_EN
            prev_next = cap_sample;
`endif
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
        // Move to the next base sample, or stop at the recorded end.
        if (i_fast || last_repeat) begin
          if (addr_plus > {1'b0, i_end_addr}) begin
            finished_next = 1'b1;
          end else begin
            addr_next = addr_plus[ADDR_W-1:0];
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Top FSM back in IDLE rewinds playback immediately, abandoning any fetch.
    if (i_state == TOP_IDLE) begin
      state_next    = S_IDLE;
      addr_next     = '0;
      cnt_next      = 3'd0;
      valid_next    = 1'b0;
      finished_next = 1'b0;
`ifdef SRAM_PLAY_INTERP_EN
      prev_next     = '0;
`endif
    end
  end

  // State register; synchronous active-low reset discards any pending fetch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      cnt_reg      <= 3'd0;
      cur_reg      <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      finished_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      cur_reg      <= cur_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      finished_reg <= finished_next;
    end
  end

`ifdef SRAM_PLAY_INTERP_EN
  // Previous base sample, the starting point of the interpolation ramp.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= prev_next;
    end
  end
`endif

  assign o_sram_addr     = addr_reg;
  // Read-only access: WE_N high, chip/output/byte enables all active.
  assign o_sram_ctrl     = 5'b10000;
  assign o_data          = data_reg;
  assign o_data_valid    = valid_reg;
  assign o_play_finished = finished_reg;

endmodule

// File: tb/tb_sram_play_reader.sv
// Self-checking bench for sram_play_reader: directed scenarios plus randomized
// playback, checked by a scoreboard against a behavioural playback model.
module tb_sram_play_reader;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    state;
  logic          fast;
  logic [3:0]    speed;
  logic [AW-1:0] end_addr;
  logic          req;
  logic [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic [4:0]    ctrl;
  logic [DW-1:0] data;
  logic          valid;
  logic          finished;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_data = mem[sram_addr];

  always #5 clk = ~clk;

  sram_play_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_state(state), .i_fast(fast),
    .i_speed(speed), .i_end_addr(end_addr), .i_sample_req(req),
    .i_sram_data(sram_data), .o_sram_addr(sram_addr), .o_sram_ctrl(ctrl),
    .o_data(data), .o_data_valid(valid), .o_play_finished(finished)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  typedef struct { int kind; int tag; int addr; int fin; } probe_t;
  exp_t   exp_q[$];
  probe_t probe_q[$];
  int checks = 0;
  int errors = 0;
  int tag_n  = 0;

  // Playback model: position, repeat index, held/previous samples, end flag.
  int          m_addr, m_cnt;
  logic [DW-1:0] m_cur, m_prev;
  bit          m_fin;

  function automatic int clamp_speed(int s);
    if (s == 0) return 1;
    if (s > 8) return 8;
    return s;
  endfunction

  task automatic model_idle();
    m_addr = 0; m_cnt = 0; m_prev = '0; m_fin = 0;
  endtask

  task automatic model_req();
    int sp, nxt, p, c;
    bit adv;
    logic [DW-1:0] v;
    if (state != 3'd1 || m_fin) return;
    sp = clamp_speed(int'(speed));
    adv = 0;
    nxt = m_addr;
    if (fast) begin
      v = mem[m_addr];
      m_cnt = 0; m_prev = v;
      nxt = m_addr + sp; adv = 1;
    end else begin
      if (m_cnt == 0) m_cur = mem[m_addr];
`ifdef SRAM_PLAY_INTERP_EN
      p = int'($signed(m_prev));
      c = int'($signed(m_cur));
      v = DW'(p + ((c - p) * (m_cnt + 1)) / sp);
`else
      p = 0; c = 0;
      v = m_cur;
`endif
      if (m_cnt + 1 >= sp) begin
        m_cnt = 0; m_prev = m_cur; nxt = m_addr + 1; adv = 1;
      end else begin
        m_cnt++;
      end
    end
    if (adv) begin
      if (nxt > int'(end_addr)) m_fin = 1;
      else m_addr = nxt;
    end
    exp_q.push_back('{d: v, due: cyc + 3});
  endtask

  task automatic probe(int kind);
    tag_n++;
    probe_q.push_back('{kind: kind, tag: tag_n, addr: m_addr, fin: int'(m_fin)});
    @(negedge clk);
  endtask

  task automatic do_req(bit twice);
    @(negedge clk);
    req = 1'b1;
    model_req();
    if (twice) @(negedge clk);   // second pulse arrives while busy and must be dropped
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_state(logic [2:0] s);
    @(negedge clk);
    state = s;
    if (s == 3'd0) model_idle();
    repeat (2) @(negedge clk);
  endtask

  function automatic void cmp(int tag, string what, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s probe %0d: got %0d, required %0d", what, tag, act, want);
    end
  endfunction

  exp_t   e;
  probe_t pr;

  // Monitor: scores every output pulse against the queue, and services state probes.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %0d at cycle %0d, required no output", data, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("sample %0d at cycle %0d (expected %0d at %0d)", data, cyc, e.d, e.due);
        if (data !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL sample: got %0d at cycle %0d, required %0d at cycle %0d", data, cyc, e.d, e.due);
        end
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++; errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_valid: got no output by cycle %0d, required %0d at cycle %0d", cyc, e.d, e.due);
    end
    if (probe_q.size() > 0) begin
      pr = probe_q.pop_front();
      case (pr.kind)
        1: begin
          cmp(pr.tag, "reset_addr", int'(sram_addr), 0);
          cmp(pr.tag, "reset_data", int'(data), 0);
          cmp(pr.tag, "reset_valid", int'(valid), 0);
          cmp(pr.tag, "reset_finished", int'(finished), 0);
          cmp(pr.tag, "sram_ctrl", int'(ctrl), 16);
        end
        2: cmp(pr.tag, "scoreboard_left", exp_q.size(), 0);
        default: begin
          cmp(pr.tag, "addr", int'(sram_addr), pr.addr);
          cmp(pr.tag, "finished", int'(finished), pr.fin);
        end
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
    rst_n = 1'b0; state = 3'd0; fast = 1'b0; speed = 4'd1; end_addr = '0; req = 1'b0;
    model_idle();
    repeat (3) @(negedge clk);
    probe(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal playback 10,20,30,40 then end.
    mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30; mem[3] = 16'd40;
    end_addr = AW'(3); fast = 1'b0; speed = 4'd1;
    set_state(3'd1);
    for (int i = 0; i < 4; i++) do_req(0);
    probe(0);
    do_req(0);
    probe(0);
    set_state(3'd0);
    probe(0);

    // Fast playback, stride 3.
    end_addr = AW'(9); fast = 1'b1; speed = 4'd3;
    set_state(3'd1);
    for (int i = 0; i < 5; i++) do_req(0);
    probe(0);

    // Reset asserted while a fetch is in flight.
    set_state(3'd0);
    set_state(3'd1);
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    probe(1);
    rst_n = 1'b1; model_idle();
    repeat (6) @(negedge clk);
    probe(2);

    // Slow playback, speed 2.
    set_state(3'd0);
    mem[0] = 16'd0; mem[1] = 16'd100;
    end_addr = AW'(1); fast = 1'b0; speed = 4'd2;
    set_state(3'd1);
    for (int i = 0; i < 4; i++) do_req(0);
    probe(0);

    // Pause and frozen record states, then resume and rewind.
    set_state(3'd0);
    end_addr = AW'(9); speed = 4'd1;
    set_state(3'd1);
    do_req(0); do_req(0);
    set_state(3'd2);
    do_req(0); do_req(0);
    probe(0);
    set_state(3'd3); do_req(0);
    set_state(3'd4); do_req(0);
    set_state(3'd1); do_req(0);
    probe(0);
    set_state(3'd0);
    probe(0);

    // Top of address space with clamped speed: must stop, not wrap.
    end_addr = '1; fast = 1'b1; speed = 4'd15;
    set_state(3'd1);
    for (int i = 0; i < 130; i++) do_req(0);
    tag_n++;
    probe_q.push_back('{kind: 0, tag: tag_n, addr: (1<<AW) - 8, fin: 1});
    @(negedge clk);
    probe(0);

    // Randomized playback.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
      end_addr = AW'($urandom_range(3, 40));
      fast = 1'($urandom_range(0, 1));
      speed = 4'($urandom_range(0, 15));
      set_state(3'd0);
      set_state(3'd1);
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 15))
          9:  do_req(1);
          10: speed = 4'($urandom_range(0, 15));
          11: fast = ~fast;
          12: begin
            set_state(3'($urandom_range(2, 4)));
            do_req(0);
            set_state(3'd1);
          end
          13: begin set_state(3'd0); set_state(3'd1); end
          default: do_req(0);
        endcase
        probe(0);
      end
    end

    repeat (4) @(negedge clk);
    probe(2);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
